// File: rtl/clock_keeper.sv
// clock_keeper: 1 Hz time-of-day counter with a button-driven set mode.
// Optional TIME_12H_EN: registered 12-hour hours output with a pm flag.
module clock_keeper #(
  parameter int CLK_HZ        = 25000000,
  parameter int RESET_HOURS   = 12,
  parameter int RESET_MINUTES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       up_btn,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       pm,
  output logic       sec_tick,
  output logic [1:0] editing
);

  localparam int PW =
    (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [PW-1:0] TC =
    PW'(CLK_HZ - 1);

  localparam logic [4:0] RH =
    5'(RESET_HOURS);

  localparam logic [5:0] RM =
    6'(RESET_MINUTES);

  typedef enum logic [1:0] {
    RUN         = 2'b00,
    SET_HOURS   = 2'b01,
    SET_MINUTES = 2'b10
  } state_t;

  state_t state_q;
  state_t state_d;

  logic mode_s0_q;
  logic mode_s1_q;
  logic mode_prev_q;
  logic up_s0_q;
  logic up_s1_q;
  logic up_prev_q;

  logic mode_edge;
  logic up_edge;

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic [4:0]    hr_q;
  logic [4:0]    hr_d;
  logic [5:0]    min_q;
  logic [5:0]    min_d;
  logic [5:0]    sec_q;
  logic [5:0]    sec_d;
  logic          tick_q;
  logic          tick_d;

  // Field increments wrap without carry;
  // any out-of-range value also goes to 0.
  function automatic logic [4:0] hr_inc(
    input logic [4:0] h
  );
    if (h >= 5'd23) begin
      return 5'd0;
    end
    return h + 5'd1;
  endfunction

  function automatic logic [5:0] ms_inc(
    input logic [5:0] v
  );
    if (v >= 6'd59) begin
      return 6'd0;
    end
    return v + 6'd1;
  endfunction

  // Two-flop synchronisers followed by a
  // previous-value register per button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_s0_q   <= 1'b0;
      mode_s1_q   <= 1'b0;
      mode_prev_q <= 1'b0;
      up_s0_q     <= 1'b0;
      up_s1_q     <= 1'b0;
      up_prev_q   <= 1'b0;
    end else begin
      mode_s0_q   <= mode_btn;
      mode_s1_q   <= mode_s0_q;
      mode_prev_q <= mode_s1_q;
      up_s0_q     <= up_btn;
      up_s1_q     <= up_s0_q;
      up_prev_q   <= up_s1_q;
    end
  end

  assign mode_edge = mode_s1_q & ~mode_prev_q;
  assign up_edge   = up_s1_q & ~up_prev_q;

  // State and time registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      presc_q <= '0;
      hr_q    <= RH;
      min_q   <= RM;
      sec_q   <= 6'd0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hr_q    <= hr_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      tick_q  <= tick_d;
    end
  end

  // Next state: timekeeping in RUN, field
  // edits in the set states. A mode edge in
  // RUN wins over a coincident terminal count.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    hr_d    = hr_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tick_d  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mode_edge) begin
          state_d = SET_HOURS;
          presc_d = '0;
          sec_d   = 6'd0;
        end else if (presc_q >= TC) begin
          presc_d = '0;
          tick_d  = 1'b1;
          sec_d   = ms_inc(sec_q);
          if (sec_q >= 6'd59) begin
            min_d = ms_inc(min_q);
            if (min_q >= 6'd59) begin
              hr_d = hr_inc(hr_q);
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      SET_HOURS: begin
        presc_d = '0;
        sec_d   = 6'd0;
        if (up_edge) begin
          hr_d = hr_inc(hr_q);
        end
        if (mode_edge) begin
          state_d = SET_MINUTES;
        end
      end
      SET_MINUTES: begin
        presc_d = '0;
        sec_d   = 6'd0;
        if (up_edge) begin
          min_d = ms_inc(min_q);
        end
        if (mode_edge) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        presc_d = '0;
      end
    endcase
  end

  assign minutes  = min_q;
  assign seconds  = sec_q;
  assign sec_tick = tick_q;
  assign editing  = state_q;

`ifdef TIME_12H_EN
  logic [4:0] hdisp_q;
  logic       pm_q;

  // 0 shows as 12, 13..23 fold to 1..11.
  function automatic logic [4:0] to12(
    input logic [4:0] h
  );
    if (h == 5'd0) begin
      return 5'd12;
    end
    if (h > 5'd12) begin
      return h - 5'd12;
    end
    return h;
  endfunction

  // Registered 12-hour view, one clk
  // behind the internal 24-hour count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdisp_q <= to12(RH);
      pm_q    <= (RH >= 5'd12);
    end else begin
      hdisp_q <= to12(hr_q);
      pm_q    <= (hr_q >= 5'd12);
    end
  end

  assign hours = hdisp_q;
  assign pm    = pm_q;
`else
  assign hours = hr_q;
  assign pm    = 1'b0;
`endif

endmodule

// File: tb/tb_clock_keeper.sv
// tb_clock_keeper: randomized scoreboard bench
// against a seconds-of-day reference model.
module tb_clock_keeper;

  localparam int HZ = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mode_btn = 1'b0;
  logic       up_btn = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       pm;
  logic       sec_tick;
  logic [1:0] editing;

  clock_keeper #(
    .CLK_HZ(HZ),
    .RESET_HOURS(12),
    .RESET_MINUTES(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode_btn(mode_btn),
    .up_btn(up_btn),
    .hours(hours),
    .minutes(minutes),
    .seconds(seconds),
    .pm(pm),
    .sec_tick(sec_tick),
    .editing(editing)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       pm;
    logic       tk;
    logic [1:0] ed;
  } obs_t;

  obs_t expq[$];
  int n_run = 0;
  int n_fail = 0;

  // Reference model: time as seconds of day,
  // mode 0/1/2, phase within the second, and
  // the sampled button history.
  int tod;
  int md;
  int phase;
  int prev_h;
  bit tick;
  bit mh[3];
  bit uh[3];

  function automatic void m_reset();
    tod = 12 * 3600;
    md = 0;
    phase = 0;
    prev_h = 12;
    tick = 0;
    for (int i = 0; i < 3; i++) begin
      mh[i] = 0;
      uh[i] = 0;
    end
  endfunction

  // A press acts on the 3rd edge after the
  // level rises: sampled high two edges ago,
  // low three edges ago.
  function automatic void m_edge(bit mb, bit ub);
    bit me;
    bit ue;
    int h;
    int mi;
    me = mh[1] && !mh[2];
    ue = uh[1] && !uh[2];
    mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = mb;
    uh[2] = uh[1]; uh[1] = uh[0]; uh[0] = ub;
    h = tod / 3600;
    mi = (tod / 60) % 60;
    prev_h = h;
    tick = 0;
    case (md)
      0: begin
        if (me) begin
          md = 1;
          phase = 0;
          tod = tod - (tod % 60);
        end else begin
          if (phase == HZ - 1) begin
            tick = 1;
            tod = (tod + 1) % 86400;
          end
          phase = (phase + 1) % HZ;
        end
      end
      1: begin
        if (ue) tod = ((h + 1) % 24) * 3600 + mi * 60;
        if (me) md = 2;
      end
      default: begin
        if (ue) tod = h * 3600 + ((mi + 1) % 60) * 60;
        if (me) begin
          md = 0;
          phase = 0;
        end
      end
    endcase
  endfunction

  function automatic obs_t m_obs();
    obs_t o;
    int h;
    h = tod / 3600;
`ifdef TIME_12H_EN
    o.h = 5'((prev_h % 12 == 0) ? 12 : prev_h % 12);
    o.pm = (prev_h >= 12);
`else
    o.h = 5'(h);
    o.pm = 1'b0;
`endif
    o.m = 6'((tod / 60) % 60);
    o.s = 6'(tod % 60);
    o.tk = tick;
    o.ed = 2'(md);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.h = hours;
    o.m = minutes;
    o.s = seconds;
    o.pm = pm;
    o.tk = sec_tick;
    o.ed = editing;
    return o;
  endfunction

  task automatic compare(string nm, obs_t a, obs_t e);
    n_run++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d:%0d:%0d pm=%0b tk=%0b ed=%0d want %0d:%0d:%0d pm=%0b tk=%0b ed=%0d",
               nm, $time, a.h, a.m, a.s, a.pm, a.tk, a.ed,
               e.h, e.m, e.s, e.pm, e.tk, e.ed);
    end
  endtask

  // Monitor: one expected entry per clock edge.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      obs_t e;
      e = expq.pop_front();
      compare("scoreboard", dut_obs(), e);
    end
  end

  task automatic step();
    @(posedge clk);
    m_edge(mode_btn, up_btn);
    expq.push_back(m_obs());
    #1;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(bit mb, bit ub);
    mode_btn = mb;
    up_btn = ub;
    steps(2);
    mode_btn = 1'b0;
    up_btn = 1'b0;
    steps(2);
  endtask

  // Called 1 time unit after a posedge.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    expq.delete();
    #1;
    m_reset();
    compare("async_reset", dut_obs(), m_obs());
    repeat (2) @(posedge clk);
    #1;
    compare("reset_hold", dut_obs(), m_obs());
    mode_btn = 1'b0;
    up_btn = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    m_reset();
    #1;
    reset = 1'b1;
    #1;
    compare("power_on_reset", dut_obs(), m_obs());
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // first ticks after reset
    steps(9);

    // 23:59 via set mode, then run past midnight
    press(1, 0);
    for (int i = 0; i < 11; i++) press(0, 1);
    press(1, 0);
    for (int i = 0; i < 59; i++) press(0, 1);
    press(1, 0);
    steps(58 * HZ + 2 * HZ + 4);

    // hours wrap in set mode, combined press
    press(1, 0);
    for (int i = 0; i < 26; i++) press(0, 1);
    press(1, 1);
    for (int i = 0; i < 3; i++) press(0, 1);
    press(1, 1);
    steps(3 * HZ);

    // held up button, reset mid-hold
    press(1, 0);
    up_btn = 1'b1;
    steps(10);
    async_reset();
    steps(2 * HZ);

    // random button activity
    for (int i = 0; i < 700; i++) begin
      int r;
      r = $urandom_range(0, 9);
      mode_btn = (r < 2);
      up_btn = (r >= 1 && r < 6);
      steps($urandom_range(1, 4));
      if ($urandom_range(0, 3) == 0) begin
        mode_btn = 1'b0;
        up_btn = 1'b0;
        steps($urandom_range(1, 3));
      end
    end
    mode_btn = 1'b0;
    up_btn = 1'b0;
    steps(4 * HZ);

    @(negedge clk);
    #1;
    n_run++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d want 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
